i2s_tdm_receiver: RTL
=====================

Name: i2s_tdm_receiver

Overview:
- Parametrised I2S/TDM bus master receiver.
- Generates bck and a frame-sync (fs), and captures SLOTS channels per frame from i2s_data.
- Delivers one word per slot over a valid/ready stream through an internal FIFO, with a sticky overflow flag.
- Sits between external ADC/codec pins and FPGA audio processing; successor to the fixed 2-channel, no-backpressure controller.

Parameters:
- DATA_BITS, 24, sample width delivered; MSB-aligned within slot; 1 ≤ DATA_BITS ≤ SLOT_BITS.
- SLOT_BITS, 32, bck periods per slot.
- SLOTS, 2, channels per frame; ≥2 and even when FS_PULSE=0.
- BCK_DIVISOR, 4, clock cycles per bck period; even, ≥2.
- DATA_DELAY, 1, bit delay of frame start relative to fs: 1 = I2S/DSP-A, 0 = left-justified/DSP-B.
- FS_PULSE, 0, fs shape: 0 = 50% duty lrck, 1 = one-bck-wide pulse.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  run bus when high; idle when low
- i2s_data  in  1  serial data from peripheral
- bck  out  1  bit clock
- fs  out  1  frame sync / lrck
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head this cycle
- m_data  out  DATA_BITS  captured sample
- m_channel  out  max(1,$clog2(SLOTS))  slot index 0..SLOTS-1
- m_last  out  1  word is slot SLOTS-1
- overflow  out  1  sticky: a word was dropped
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset: bck=0, fs=0, m_valid=0, m_data=0, m_channel=0, m_last=0, overflow=0; FIFO empty; counters 0; state IDLE.
- States:
  - IDLE: bck=0, fs=0, counters held at 0.
  - IDLE→RUN when enable is sampled high. The next cycle has phase p=0, bit index b=0, fs=f(0), bck=0.
  - RUN→IDLE when enable is sampled low: next cycle bck=0, fs=0, p=b=0, partial slot discarded (no push); FIFO contents retained and drainable.
- Definitions:
  - F = SLOTS*SLOT_BITS. p counts 0..BCK_DIVISOR-1 and wraps.
  - Rising event: the cycle with p==BCK_DIVISOR/2-1. bck<=1; i2s_data is shifted MSB-first into the slot shift register in that cycle.
  - Falling event: the cycle with p==BCK_DIVISOR-1. bck<=0; b<=(b+1) mod F; fs<=f((b+1) mod F).
  - Result: bck has 50% duty and period BCK_DIVISOR clocks.
- fs function: j=(b+DATA_DELAY) mod F.
  - FS_PULSE=0: f(b) = (j ≥ F/2).
  - FS_PULSE=1: f(b) = (j == 0).
- Slot capture: slot s = b / SLOT_BITS; k = b mod SLOT_BITS.
  - On the rising event with k==SLOT_BITS-1, push {data = top DATA_BITS of the completed slot, channel = s, last = (s==SLOTS-1)}.
  - Push is visible as m_valid=1 on the next cycle if the FIFO was empty (1-cycle latency from final sample edge).
- FIFO:
  - First-word-fall-through; head drives m_data/m_channel/m_last.
  - Pop when m_valid & m_ready.
  - m_data/m_channel/m_last are 0 when empty.
  - Order is strictly preserved.
- Push when full: accepted if a pop occurs in the same cycle; otherwise the word is dropped and overflow<=1.
- overflow: clear_overflow clears it; a simultaneous drop and clear leaves overflow=1.
- Simultaneous push and pop on an empty FIFO: m_valid stays 0 that cycle; the new word is valid the next cycle.
- Reset mid-frame or with a non-empty FIFO returns everything to reset values on the next cycle.

Test Plan:
- Defaults. Drive left slot 0xA5A5A5FF, right slot 0x123456_00 MSB-first on bck falling edges, m_ready=1.
  - Words: 0xA5A5A5 ch0 last0, then 0x123456 ch1 last1.
  - bck period 4 clocks; frame 256 clocks.
  - fs high exactly during b=31..62.
- SLOTS=8, SLOT_BITS=16, DATA_BITS=16, FS_PULSE=1, DATA_DELAY=0. Drive slot n = 0x1000+n.
  - fs high only during b=0.
  - 8 words 0x1000..0x1007, channels 0..7, m_last only on ch7.
- Defaults, m_ready=0 for 3 frames (6 words), FIFO_DEPTH=4.
  - overflow rises at the 5th push.
  - Assert clear_overflow → overflow=0.
  - Raise m_ready → exactly the first 4 words, in order, then m_valid=0.
- Deassert enable at b=10.
  - Next cycle bck=0, fs=0; no word pushed for the partial slot.
  - Re-enable → fs=f(0), first word appears after a full slot (32 bck).
- Assert reset mid-frame with 2 words queued → next cycle m_valid=0, overflow=0, bck=0, fs=0.
- BCK_DIVISOR=2 → bck toggles every clock; capture is correct with a continuous alternating 0x55555555 pattern (word 0x555555).

Source files
------------

// File: rtl/i2s_tdm_receiver.sv
// i2s_tdm_receiver
//   I2S/TDM bus master receiver. Generates the bit clock (bck) and frame sync
//   (fs), samples i2s_data MSB-first on every bck rising event, and pushes one
//   word per completed slot into a first-word-fall-through FIFO that feeds a
//   valid/ready stream. Words that arrive while the FIFO is full (and nothing
//   is popped that cycle) are dropped and set a sticky overflow flag.
//
// Ports
//   clock, reset       system clock, synchronous active-high reset
//   enable             run the bus when high, idle (bck=fs=0) when low
//   i2s_data           serial data from the peripheral
//   bck, fs            generated bit clock and frame sync / lrck
//   m_valid, m_ready   output stream handshake (pop when both high)
//   m_data             captured sample, top DATA_BITS of the slot
//   m_channel, m_last  slot index of the word; m_last marks slot SLOTS-1
//   overflow           sticky drop indicator, cleared by clear_overflow
module i2s_tdm_receiver #(
    parameter int DATA_BITS   = 24,
    parameter int SLOT_BITS   = 32,
    parameter int SLOTS       = 2,
    parameter int BCK_DIVISOR = 4,
    parameter int DATA_DELAY  = 1,
    parameter int FS_PULSE    = 0,
    parameter int FIFO_DEPTH  = 4,
    localparam int CH_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 i2s_data,
    output logic                 bck,
    output logic                 fs,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic [CH_W-1:0]      m_channel,
    output logic                 m_last,
    output logic                 overflow,
    input  logic                 clear_overflow
);

    localparam int F     = SLOTS * SLOT_BITS;
    localparam int K_W   = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int P_W   = $clog2(BCK_DIVISOR);
    localparam int A_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W = A_W + 1;
    localparam int E_W   = DATA_BITS + CH_W + 1;

    localparam logic [P_W-1:0]  P_RISE = P_W'(BCK_DIVISOR / 2 - 1);
    localparam logic [P_W-1:0]  P_FALL = P_W'(BCK_DIVISOR - 1);
    localparam logic [K_W-1:0]  K_LAST = K_W'(SLOT_BITS - 1);
    localparam logic [CH_W-1:0] S_LAST = CH_W'(SLOTS - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Frame-sync level for frame bit b = slot*SLOT_BITS + bit_idx.
    function automatic logic f_fs(input logic [CH_W-1:0] slot, input logic [K_W-1:0] bit_idx);
        int j;
        j = int'(slot) * SLOT_BITS + int'(bit_idx) + DATA_DELAY;
        if (j >= F) j = j - F;
        if (FS_PULSE != 0) return (j == 0);
        else               return (j >= F / 2);
    endfunction

    state_t              r_state, w_state_next;
    logic [P_W-1:0]      r_phase;
    logic [K_W-1:0]      r_bit, w_bit_next;
    logic [CH_W-1:0]     r_slot, w_slot_next;
    logic                r_bck, r_fs;
    logic [SLOT_BITS-1:0] r_shift, w_slot_word;
    logic                w_run, w_rise, w_fall, w_push;
    logic [E_W-1:0]      w_push_entry, w_head;

    logic [E_W-1:0]      r_mem [FIFO_DEPTH];
    logic [A_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                w_full, w_pop, w_accept, w_drop;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // w_run marks a cycle in which the bus actually advances; the cycle that
    // samples enable low leaves RUN without a rising event or a push.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_RUN;
            ST_RUN: begin
                if (enable) w_run = 1'b1;
                else        w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_rise      = w_run & (r_phase == P_RISE);
    assign w_fall      = w_run & (r_phase == P_FALL);
    assign w_push      = w_rise & (r_bit == K_LAST);
    assign w_slot_word = (r_shift << 1) | SLOT_BITS'(i2s_data);
    assign w_bit_next  = (r_bit == K_LAST) ? '0 : r_bit + K_W'(1);
    assign w_slot_next = (r_bit != K_LAST) ? r_slot :
                         (r_slot == S_LAST) ? '0 : r_slot + CH_W'(1);
    assign w_push_entry = {(r_slot == S_LAST), r_slot, w_slot_word[SLOT_BITS-1 -: DATA_BITS]};

    // Bus timing: phase, bit/slot counters, bck and fs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_slot  <= '0;
            r_bck   <= 1'b0;
            r_fs    <= 1'b0;
        end else if (!w_run) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_slot  <= '0;
            r_bck   <= 1'b0;
            // Entering RUN presents the level for frame bit 0 immediately.
            r_fs    <= (r_state == ST_IDLE && enable) ? f_fs('0, '0) : 1'b0;
        end else begin
            r_phase <= (r_phase == P_FALL) ? '0 : r_phase + P_W'(1);
            if (w_rise) r_bck <= 1'b1;
            if (w_fall) begin
                r_bck  <= 1'b0;
                r_bit  <= w_bit_next;
                r_slot <= w_slot_next;
                r_fs   <= f_fs(w_slot_next, w_bit_next);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_rise) r_shift <= w_slot_word;
    end

    // Output FIFO: a full FIFO still accepts a push when the head pops.
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign m_valid  = (r_count != '0);
    assign w_pop    = m_valid & m_ready;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & ~w_accept;

    always_ff @(posedge clock) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_push_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + A_W'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + A_W'(1);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear wins.
            r_overflow <= w_drop | (r_overflow & ~clear_overflow);
        end
    end

    assign w_head    = m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_data    = w_head[DATA_BITS-1:0];
    assign m_channel = w_head[DATA_BITS +: CH_W];
    assign m_last    = w_head[E_W-1];
    assign bck       = r_bck;
    assign fs        = r_fs;
    assign overflow  = r_overflow;

endmodule
